// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the regfile's single write/unlock port among NUM_REQ writeback
//   sources (ALU, MUL, DIV, LSU). Grants at most one source per cycle,
//   round-robin, and drives the regfile wr_unlock_en/addr/data inputs.
//
// Parameters
//   NUM_REQ  number of writeback requesters (>= 2)
//   XLEN     data width
//   AW       register address width
//
// Ports
//   clk_i             clock, all state on posedge
//   srst_i            synchronous reset, active-high
//   req_valid_i       per-requester result valid
//   req_addr_i        per-requester destination register
//   req_data_i        per-requester result data
//   req_ready_o       one-hot grant (comb); handshake = valid & ready
//   wr_unlock_en_o    regfile write/unlock enable
//   wr_unlock_addr_o  regfile write/unlock address
//   wr_unlock_data_o  regfile write/unlock data
//   grant_idx_o       index of current grant, 0 if none (comb)
//   collision_o       two valid requesters target the same non-zero reg (comb)
//
// Build option
//   REGFILE_WB_ARB_REG_OUT_EN: register wr_unlock_* (write lands one cycle
//   after the handshake). Undefined: wr_unlock_* are combinational.

module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned AW      = 5
) (
    input  logic                          clk_i,
    input  logic                          srst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0][AW-1:0]    req_addr_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          wr_unlock_en_o,
    output logic [AW-1:0]                 wr_unlock_addr_o,
    output logic [XLEN-1:0]               wr_unlock_data_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx_o,
    output logic                          collision_o
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   w_ptr_nxt;
    logic [IW-1:0]   w_scan;
    logic [IW-1:0]   w_gidx;
    logic            w_found;
    logic            w_hs;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [XLEN-1:0] w_wr_data;
    logic            w_collision;

    // Round-robin pointer: index that currently has highest priority
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_ptr_nxt;
        end
    end

    // Scan from r_rr_ptr upward (mod NUM_REQ); first valid requester wins
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_scan  = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            w_scan = IW'((int'(r_rr_ptr) + k) % int'(NUM_REQ));
            if (!w_found && req_valid_i[w_scan]) begin
                w_found = 1'b1;
                w_gidx  = w_scan;
            end
        end
    end

    // Handshake, pointer advance and write selection
    always_comb begin
        w_hs      = w_found && !srst_i;
        w_ptr_nxt = r_rr_ptr;
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        if (w_hs) begin
            w_ptr_nxt = (w_gidx == IW'(NUM_REQ - 1)) ? '0 : w_gidx + IW'(1);
            // x0 writes complete the handshake but never reach the regfile
            if (req_addr_i[w_gidx] != '0) begin
                w_wr_en   = 1'b1;
                w_wr_addr = req_addr_i[w_gidx];
                w_wr_data = req_data_i[w_gidx];
            end
        end
    end

    // Diagnostic: any pair of valid requesters aimed at the same non-zero reg
    always_comb begin
        w_collision = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            for (int j = i + 1; j < int'(NUM_REQ); j++) begin
                if (req_valid_i[i] && req_valid_i[j] &&
                    (req_addr_i[i] != '0) && (req_addr_i[i] == req_addr_i[j])) begin
                    w_collision = 1'b1;
                end
            end
        end
        if (srst_i) begin
            w_collision = 1'b0;
        end
    end

    assign req_ready_o = w_hs ? (NUM_REQ'(1) << w_gidx) : '0;
    assign grant_idx_o = w_hs ? w_gidx : '0;
    assign collision_o = w_collision;

`ifdef REGFILE_WB_ARB_REG_OUT_EN
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [XLEN-1:0] r_wr_data;

    // One-cycle write pipeline toward the regfile
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
        end
    end

    assign wr_unlock_en_o   = r_wr_en;
    assign wr_unlock_addr_o = r_wr_addr;
    assign wr_unlock_data_o = r_wr_data;
`else
    assign wr_unlock_en_o   = w_wr_en;
    assign wr_unlock_addr_o = w_wr_addr;
    assign wr_unlock_data_o = w_wr_data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vector table for the named
// scenarios, then random traffic against a priority-queue reference model.

module tb_regfile_wb_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned XL  = 32;
    localparam int unsigned AWB = 5;

    logic                     clk_i  = 1'b0;
    logic                     srst_i = 1'b1;
    logic [NR-1:0]            req_valid_i = '0;
    logic [NR-1:0][AWB-1:0]   req_addr_i  = '0;
    logic [NR-1:0][XL-1:0]    req_data_i  = '0;
    logic [NR-1:0]            req_ready_o;
    logic                     wr_unlock_en_o;
    logic [AWB-1:0]           wr_unlock_addr_o;
    logic [XL-1:0]            wr_unlock_data_o;
    logic [1:0]               grant_idx_o;
    logic                     collision_o;

    regfile_wb_arbiter #(.NUM_REQ(NR), .XLEN(XL), .AW(AWB)) dut (
        .clk_i            (clk_i),
        .srst_i           (srst_i),
        .req_valid_i      (req_valid_i),
        .req_addr_i       (req_addr_i),
        .req_data_i       (req_data_i),
        .req_ready_o      (req_ready_o),
        .wr_unlock_en_o   (wr_unlock_en_o),
        .wr_unlock_addr_o (wr_unlock_addr_o),
        .wr_unlock_data_o (wr_unlock_data_o),
        .grant_idx_o      (grant_idx_o),
        .collision_o      (collision_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic                   srst;
        logic [NR-1:0]          valid;
        logic [NR-1:0][AWB-1:0] addr;
        logic [NR-1:0][XL-1:0]  data;
        logic [NR-1:0]          ready;
        logic                   en;
        logic [AWB-1:0]         waddr;
        logic [XL-1:0]          wdata;
        logic [1:0]             gidx;
        logic                   coll;
    } vec_t;

    localparam logic [19:0]  A1234 = {5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [19:0]  A_X0  = {5'd4, 5'd0, 5'd2, 5'd1};
    localparam logic [19:0]  A_C7  = {5'd4, 5'd3, 5'd7, 5'd7};
    localparam logic [19:0]  A_Z   = {5'd4, 5'd3, 5'd0, 5'd0};
    localparam logic [19:0]  A_56  = {5'd4, 5'd3, 5'd6, 5'd5};
    localparam logic [127:0] D     = {32'h103, 32'h102, 32'h101, 32'h100};
    localparam logic [127:0] D_X0  = {32'h103, 32'hDEAD, 32'h101, 32'h100};
    localparam logic [127:0] D_C   = {32'h103, 32'h102, 32'hA1, 32'hA0};
    localparam logic [127:0] D_56  = {32'h103, 32'h102, 32'h600, 32'h500};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: priority order as a rotating queue
    int             prio[$];
    logic           d_en   = 1'b0;
    logic [AWB-1:0] d_addr = '0;
    logic [XL-1:0]  d_data = '0;

    function automatic vec_t mk(logic s, logic [3:0] va, logic [19:0] ad, logic [127:0] da,
                                logic [3:0] rd, logic en, logic [4:0] wa, logic [31:0] wd,
                                logic [1:0] g, logic c);
        vec_t v;
        v.srst = s; v.valid = va; v.addr = ad; v.data = da;
        v.ready = rd; v.en = en; v.waddr = wa; v.wdata = wd; v.gidx = g; v.coll = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_prio();
        prio.delete();
        for (int i = 0; i < int'(NR); i++) prio.push_back(i);
    endtask

    // One clock: compute expectations, check at negedge, advance model
    task automatic run_cycle(input bit use_tab, input vec_t v,
                             output logic [NR-1:0] act_ready, output int mg);
        logic [NR-1:0]  e_ready;
        logic           e_en, t_en;
        logic [AWB-1:0] e_addr, t_addr;
        logic [XL-1:0]  e_data, t_data;
        logic [1:0]     e_g;
        logic           e_coll;
        mg = -1;
        if (!srst_i) begin
            foreach (prio[k]) if (mg < 0 && req_valid_i[prio[k]]) mg = prio[k];
        end
        e_ready = '0; e_en = 1'b0; e_addr = '0; e_data = '0; e_g = '0; e_coll = 1'b0;
        if (mg >= 0) begin
            e_ready[mg] = 1'b1;
            e_g = 2'(mg);
            if (req_addr_i[mg] != '0) begin
                e_en = 1'b1; e_addr = req_addr_i[mg]; e_data = req_data_i[mg];
            end
        end
        if (!srst_i) begin
            for (int i = 0; i < int'(NR); i++)
                for (int j = 0; j < int'(NR); j++)
                    if (i != j && req_valid_i[i] && req_valid_i[j] &&
                        req_addr_i[i] != '0 && req_addr_i[i] == req_addr_i[j]) e_coll = 1'b1;
        end
        if (use_tab) begin
            e_ready = v.ready; e_en = v.en; e_addr = v.waddr; e_data = v.wdata;
            e_g = v.gidx; e_coll = v.coll;
        end
`ifdef REGFILE_WB_ARB_REG_OUT_EN
        t_en = e_en; t_addr = e_addr; t_data = e_data;
        e_en = d_en; e_addr = d_addr; e_data = d_data;
        d_en   = srst_i ? 1'b0 : t_en;
        d_addr = srst_i ? '0 : t_addr;
        d_data = srst_i ? '0 : t_data;
`else
        t_en = 1'b0; t_addr = '0; t_data = '0;
`endif
        @(negedge clk_i);
        chk("ready",     32'(req_ready_o),      32'(e_ready));
        chk("wr_en",     32'(wr_unlock_en_o),   32'(e_en));
        chk("wr_addr",   32'(wr_unlock_addr_o), 32'(e_addr));
        chk("wr_data",   wr_unlock_data_o,      e_data);
        chk("grant_idx", 32'(grant_idx_o),      32'(e_g));
        chk("collision", 32'(collision_o),      32'(e_coll));
        act_ready = req_ready_o;
        if (srst_i) reset_prio();
        else if (mg >= 0) while (prio[$] != mg) prio.push_back(prio.pop_front());
        @(posedge clk_i);
        #1;
    endtask

    // Requester contract: a pending request holds valid/addr/data until handshake
    logic [NR-1:0]          pv  = '0;
    logic [NR-1:0]          phs = '0;
    logic [NR-1:0][AWB-1:0] pa  = '0;
    logic [NR-1:0][XL-1:0]  pd  = '0;
    always @(negedge clk_i) begin
        for (int i = 0; i < int'(NR); i++) begin
            if (pv[i] && !phs[i]) begin
                assert (req_valid_i[i] && req_addr_i[i] == pa[i] && req_data_i[i] == pd[i])
                    else $error("requester %0d changed its pending request", i);
            end
        end
        pv  <= req_valid_i;
        phs <= req_valid_i & req_ready_o;
        pa  <= req_addr_i;
        pd  <= req_data_i;
    end

    vec_t                   tab[23];
    vec_t                   dummy;
    logic [NR-1:0]          ar;
    int                     mg;
    logic [NR-1:0]          pend;
    logic [NR-1:0][AWB-1:0] ra;
    logic [NR-1:0][XL-1:0]  rdat;
    int                     waitc[NR];

    initial begin
        tab[0]  = mk(1, 4'hF, A1234, D,    4'h0, 0, 5'd0, 32'h0,   2'd0, 0);
        tab[1]  = mk(0, 4'hF, A1234, D,    4'h1, 1, 5'd1, 32'h100, 2'd0, 0);
        tab[2]  = mk(0, 4'hF, A1234, D,    4'h2, 1, 5'd2, 32'h101, 2'd1, 0);
        tab[3]  = mk(0, 4'hF, A1234, D,    4'h4, 1, 5'd3, 32'h102, 2'd2, 0);
        tab[4]  = mk(0, 4'hF, A1234, D,    4'h8, 1, 5'd4, 32'h103, 2'd3, 0);
        tab[5]  = mk(0, 4'hF, A1234, D,    4'h1, 1, 5'd1, 32'h100, 2'd0, 0);
        tab[6]  = mk(0, 4'hE, A1234, D,    4'h2, 1, 5'd2, 32'h101, 2'd1, 0);
        tab[7]  = mk(0, 4'hC, A1234, D,    4'h4, 1, 5'd3, 32'h102, 2'd2, 0);
        tab[8]  = mk(0, 4'h8, A1234, D,    4'h8, 1, 5'd4, 32'h103, 2'd3, 0);
        tab[9]  = mk(0, 4'h4, A_X0,  D_X0, 4'h4, 0, 5'd0, 32'h0,   2'd2, 0);
        tab[10] = mk(0, 4'hA, A1234, D,    4'h8, 1, 5'd4, 32'h103, 2'd3, 0);
        tab[11] = mk(0, 4'hA, A1234, D,    4'h2, 1, 5'd2, 32'h101, 2'd1, 0);
        tab[12] = mk(0, 4'hA, A1234, D,    4'h8, 1, 5'd4, 32'h103, 2'd3, 0);
        tab[13] = mk(0, 4'h2, A1234, D,    4'h2, 1, 5'd2, 32'h101, 2'd1, 0);
        tab[14] = mk(0, 4'h3, A_C7,  D_C,  4'h1, 1, 5'd7, 32'hA0,  2'd0, 1);
        tab[15] = mk(0, 4'h2, A_C7,  D_C,  4'h2, 1, 5'd7, 32'hA1,  2'd1, 0);
        tab[16] = mk(0, 4'h3, A_Z,   D,    4'h1, 0, 5'd0, 32'h0,   2'd0, 0);
        tab[17] = mk(0, 4'h2, A_Z,   D,    4'h2, 0, 5'd0, 32'h0,   2'd1, 0);
        tab[18] = mk(0, 4'h0, A_Z,   D,    4'h0, 0, 5'd0, 32'h0,   2'd0, 0);
        tab[19] = mk(0, 4'h3, A_56,  D_56, 4'h1, 1, 5'd5, 32'h500, 2'd0, 0);
        tab[20] = mk(1, 4'h3, A_56,  D_56, 4'h0, 0, 5'd0, 32'h0,   2'd0, 0);
        tab[21] = mk(0, 4'h3, A_56,  D_56, 4'h1, 1, 5'd5, 32'h500, 2'd0, 0);
        tab[22] = mk(0, 4'h2, A_56,  D_56, 4'h2, 1, 5'd6, 32'h600, 2'd1, 0);
        dummy = tab[0];
        reset_prio();

        // Initial reset: clear all DUT state before the first check
        srst_i = 1'b1;
        @(posedge clk_i);
        #1;
        run_cycle(1'b0, dummy, ar, mg);

        // Directed vectors; state carries from row to row
        for (int i = 0; i < 23; i++) begin
            srst_i      = tab[i].srst;
            req_valid_i = tab[i].valid;
            req_addr_i  = tab[i].addr;
            req_data_i  = tab[i].data;
            run_cycle(1'b1, tab[i], ar, mg);
        end

        // Random traffic honouring the requester contract
        pend = '0; ra = '0; rdat = '0;
        for (int i = 0; i < int'(NR); i++) waitc[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < int'(NR); i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    ra[i]   = 5'($urandom_range(0, 9));
                    rdat[i] = $urandom;
                end
            end
            srst_i      = ($urandom_range(0, 49) == 0);
            req_valid_i = pend;
            req_addr_i  = ra;
            req_data_i  = rdat;
            run_cycle(1'b0, dummy, ar, mg);
            for (int i = 0; i < int'(NR); i++) begin
                if (srst_i) begin
                    waitc[i] = 0;
                end else if (pend[i]) begin
                    if (ar[i]) begin
                        chk("fair_wait", 32'(waitc[i] < int'(NR)), 32'd1);
                        waitc[i] = 0;
                    end else begin
                        waitc[i]++;
                    end
                end
            end
            if (mg >= 0) pend[mg] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
